// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage holding the EX/MEM and MEM/WB registers,
// performing loads/stores over a ready-handshaked port with a wait-state timeout.
module mem_stage #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_E,
    input  logic [31:0] ALU_out_E,
    input  logic [31:0] rdata2_fd,
    input  logic [4:0]  rd_E,
    input  logic        RegWrite_E,
    input  logic        MemRead_E,
    input  logic        MemWrite_E,
    input  logic [2:0]  funct3_E,
    input  logic        flush_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALU_out_M,
    output logic [4:0]  rd_M,
    output logic        RegWrite_M,
    output logic [31:0] ALU_out_W,
    output logic [31:0] mem_read_data_W,
    output logic [4:0]  rd_W,
    output logic        RegWrite_W,
    output logic        MemToReg_W,
    output logic        stall_M,
    output logic        mem_exc_M
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic        valid_q, rw_q, mr_q, mw_q;
    logic [31:0] alu_q, sdata_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [0:0]  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] alu_w_q, ld_w_q;
    logic [4:0]  rd_w_q;
    logic        rw_w_q, m2r_w_q;

    logic        memop, act, f3_ok, aligned, legal, timeout, done, wb_valid;
    logic [1:0]  a;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_fmt, wdata_raw;
    logic [3:0]  be_raw;

    assign a        = alu_q[1:0];
    assign memop    = valid_q & (mr_q | mw_q);
    assign act      = memop & ~flush_M;
    assign f3_ok    = mr_q ? (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (f3_q inside {3'b000, 3'b001, 3'b010});
    assign aligned  = (f3_q[1:0] == 2'b01) ? ~a[0] :
                      (f3_q[1:0] == 2'b10) ? (a == 2'b00) : 1'b1;
    assign legal    = f3_ok & aligned;
    // The timeout cycle carries no request, so a late ready is simply ignored.
    assign timeout  = (state_q == S_WAIT) & (cnt_q == LAST) & act;
    assign dmem_req = act & legal & ~timeout;
    assign done     = dmem_req & dmem_ready;
    assign stall_M  = act & legal & ~done & ~timeout;
    assign mem_exc_M = act & (~legal | timeout);
    assign wb_valid = valid_q & ~flush_M & (~memop | done);

    assign be_raw    = (f3_q[1:0] == 2'b00) ? (4'b0001 << a) :
                       (f3_q[1:0] == 2'b01) ? (4'b0011 << a) : 4'b1111;
    assign wdata_raw = (f3_q[1:0] == 2'b00) ? {4{sdata_q[7:0]}} :
                       (f3_q[1:0] == 2'b01) ? {2{sdata_q[15:0]}} : sdata_q;
    assign dmem_we    = dmem_req & mw_q;
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;
    assign dmem_wdata = dmem_we ? wdata_raw : 32'h0;
    assign dmem_addr  = dmem_req ? {alu_q[31:2], 2'b00} : 32'h0;

    assign lb = a[1] ? (a[0] ? dmem_rdata[31:24] : dmem_rdata[23:16])
                     : (a[0] ? dmem_rdata[15:8]  : dmem_rdata[7:0]);
    assign lh = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ld_fmt = (f3_q == 3'b000) ? {{24{lb[7]}}, lb} :
                    (f3_q == 3'b001) ? {{16{lh[15]}}, lh} :
                    (f3_q == 3'b100) ? {24'h0, lb} :
                    (f3_q == 3'b101) ? {16'h0, lh} : dmem_rdata;

    always_comb begin
        state_d = (dmem_req & ~dmem_ready) ? S_WAIT : S_IDLE;
        cnt_d   = (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            alu_q   <= 32'h0;
            sdata_q <= 32'h0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
        end else begin
            if (flush_M) begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
            end else if (!stall_M) begin
                valid_q <= valid_E;
                rw_q    <= RegWrite_E & valid_E;
            end
            if (!stall_M) begin
                mr_q    <= MemRead_E;
                mw_q    <= MemWrite_E;
                alu_q   <= ALU_out_E;
                sdata_q <= rdata2_fd;
                rd_q    <= rd_E;
                f3_q    <= funct3_E;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alu_w_q <= 32'h0;
            ld_w_q  <= 32'h0;
            rd_w_q  <= 5'd0;
            rw_w_q  <= 1'b0;
            m2r_w_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_w_q <= alu_q;
            ld_w_q  <= (wb_valid & mr_q) ? ld_fmt : 32'h0;
            rd_w_q  <= rd_q;
            rw_w_q  <= wb_valid & rw_q;
            m2r_w_q <= wb_valid & mr_q;
        end
    end

    assign ALU_out_M       = alu_q;
    assign rd_M            = rd_q;
    assign RegWrite_M      = rw_q;
    assign ALU_out_W       = alu_w_q;
    assign mem_read_data_W = ld_w_q;
    assign rd_W            = rd_w_q;
    assign RegWrite_W      = rw_w_q;
    assign MemToReg_W      = m2r_w_q;
endmodule
